// File: rtl/cpu64_obi_mem_arbiter.sv
// cpu64_obi_mem_arbiter: shares one OBI memory port between the I-side and
// D-side refill masters. Round-robin selection with address-phase locking. An
// in-order ID FIFO routes each response back to the port that issued it.
// Optional grant/conflict counters are enabled by CPU64_MEM_ARB_PERF_CNT_EN.
module cpu64_obi_mem_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req_i,
    output logic                  i_gnt_o,
    input  logic [ADDR_W-1:0]     i_addr_i,
    input  logic                  i_we_i,
    input  logic [DATA_W/8-1:0]   i_be_i,
    input  logic [DATA_W-1:0]     i_wdata_i,
    output logic                  i_rvalid_o,
    output logic [DATA_W-1:0]     i_rdata_o,
    input  logic                  d_req_i,
    output logic                  d_gnt_o,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic                  d_we_i,
    input  logic [DATA_W/8-1:0]   d_be_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic                  d_rvalid_o,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  err_o
`ifdef CPU64_MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           i_grant_cnt_o,
    output logic [31:0]           d_grant_cnt_o,
    output logic [31:0]           conflict_cnt_o
`endif
);

    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam logic        PORT_I = 1'b0;
    localparam logic        PORT_D = 1'b1;

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [MAX_OUT-1:0] id_q, id_d;
    logic               lock_q, lock_d;
    logic               lock_port_q, lock_port_d;
    logic               last_grant_q, last_grant_d;
    logic               err_q, err_d;

    logic sel_valid, sel_port, sel_req, full, push, pop, head_id;

    // Port selection: a locked port wins outright, otherwise round-robin.
    always_comb begin
        sel_valid = 1'b0;
        sel_port  = PORT_I;
        if (lock_q) begin
            sel_valid = 1'b1;
            sel_port  = lock_port_q;
        end else if (i_req_i && d_req_i) begin
            sel_valid = 1'b1;
            sel_port  = ~last_grant_q;
        end else if (i_req_i || d_req_i) begin
            sel_valid = 1'b1;
            sel_port  = d_req_i;
        end
    end

    assign full    = (count_q == CNT_W'(MAX_OUT));
    assign sel_req = sel_valid && ((sel_port == PORT_D) ? d_req_i : i_req_i);
    assign push    = mem_req_o && mem_gnt_i;
    assign pop     = mem_rvalid_i && (count_q != '0);
    assign head_id = id_q[rptr_q];

    // Address-phase mux and grant/response routing, all zero-latency.
    always_comb begin
        mem_req_o   = sel_req && !full;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        i_gnt_o     = 1'b0;
        d_gnt_o     = 1'b0;
        if (sel_valid && (sel_port == PORT_D)) begin
            mem_addr_o  = d_addr_i;
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_wdata_o = d_wdata_i;
            d_gnt_o     = mem_gnt_i && mem_req_o;
        end else if (sel_valid) begin
            mem_addr_o  = i_addr_i;
            mem_we_o    = i_we_i;
            mem_be_o    = i_be_i;
            mem_wdata_o = i_wdata_i;
            i_gnt_o     = mem_gnt_i && mem_req_o;
        end
        i_rvalid_o = pop && (head_id == PORT_I);
        d_rvalid_o = pop && (head_id == PORT_D);
        i_rdata_o  = mem_rdata_i;
        d_rdata_o  = mem_rdata_i;
        err_o      = err_q;
    end

    // Next-state for lock, round-robin history, ID FIFO and sticky error.
    always_comb begin
        lock_d       = lock_q;
        lock_port_d  = lock_port_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        err_d        = err_q || (mem_rvalid_i && (count_q == '0));
        if (push) begin
            lock_d       = 1'b0;
            last_grant_d = sel_port;
            id_d[wptr_q] = sel_port;
            wptr_d       = (wptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wptr_q + PTR_W'(1);
        end else if (mem_req_o) begin
            // Stalled address phase: hold this port until its handshake.
            lock_d      = 1'b1;
            lock_port_d = sel_port;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            id_q         <= '0;
            lock_q       <= 1'b0;
            lock_port_q  <= PORT_I;
            last_grant_q <= PORT_I;
            err_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            id_q         <= id_d;
            lock_q       <= lock_d;
            lock_port_q  <= lock_port_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

`ifdef CPU64_MEM_ARB_PERF_CNT_EN
    logic [31:0] i_grant_cnt_q, i_grant_cnt_d;
    logic [31:0] d_grant_cnt_q, d_grant_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    // Free-running wrapping counters for grants and contention.
    always_comb begin
        i_grant_cnt_d  = i_grant_cnt_q + {31'd0, i_gnt_o};
        d_grant_cnt_d  = d_grant_cnt_q + {31'd0, d_gnt_o};
        conflict_cnt_d = conflict_cnt_q + {31'd0, (i_req_i && d_req_i && !lock_q)};
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_grant_cnt_q  <= '0;
            d_grant_cnt_q  <= '0;
            conflict_cnt_q <= '0;
        end else begin
            i_grant_cnt_q  <= i_grant_cnt_d;
            d_grant_cnt_q  <= d_grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign i_grant_cnt_o  = i_grant_cnt_q;
    assign d_grant_cnt_o  = d_grant_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cpu64_obi_mem_arbiter.sv
// Directed bench for cpu64_obi_mem_arbiter with hand-computed expectations.
module tb_cpu64_obi_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        i_req_i, i_gnt_o, i_we_i, i_rvalid_o;
    logic [63:0] i_addr_i, i_wdata_i, i_rdata_o;
    logic [7:0]  i_be_i;
    logic        d_req_i, d_gnt_o, d_we_i, d_rvalid_o;
    logic [63:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic [7:0]  d_be_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, err_o;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [7:0]  mem_be_o;
`ifdef CPU64_MEM_ARB_PERF_CNT_EN
    logic [31:0] i_grant_cnt_o, d_grant_cnt_o, conflict_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cpu64_obi_mem_arbiter #(
        .ADDR_W (64),
        .DATA_W (64),
        .MAX_OUT(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_req_i     (i_req_i),
        .i_gnt_o     (i_gnt_o),
        .i_addr_i    (i_addr_i),
        .i_we_i      (i_we_i),
        .i_be_i      (i_be_i),
        .i_wdata_i   (i_wdata_i),
        .i_rvalid_o  (i_rvalid_o),
        .i_rdata_o   (i_rdata_o),
        .d_req_i     (d_req_i),
        .d_gnt_o     (d_gnt_o),
        .d_addr_i    (d_addr_i),
        .d_we_i      (d_we_i),
        .d_be_i      (d_be_i),
        .d_wdata_i   (d_wdata_i),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
`ifdef CPU64_MEM_ARB_PERF_CNT_EN
        ,
        .i_grant_cnt_o (i_grant_cnt_o),
        .d_grant_cnt_o (d_grant_cnt_o),
        .conflict_cnt_o(conflict_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_req_i = 0; i_addr_i = '0; i_we_i = 0; i_be_i = '0; i_wdata_i = '0;
        d_req_i = 0; d_addr_i = '0; d_we_i = 0; d_be_i = '0; d_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    // Advance one clock; inputs change 1 ns after the edge, checks 1 ns later.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 0;
        #3;
        check_eq("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check_eq("rst_err", {63'd0, err_o}, 64'd0);
        cyc();
        rst_ni = 1;
        #1;
    endtask

    initial begin
        do_reset();
        check_eq("idle_gnts", {62'd0, i_gnt_o, d_gnt_o}, 64'd0);
        check_eq("idle_addr", mem_addr_o, 64'd0);

        // Single I read, granted immediately, response two cycles later.
        i_req_i = 1; i_addr_i = 64'h1000; mem_gnt_i = 1; #1;
        check_eq("rd_i_gnt", {63'd0, i_gnt_o}, 64'd1);
        check_eq("rd_d_gnt", {63'd0, d_gnt_o}, 64'd0);
        check_eq("rd_addr", mem_addr_o, 64'h1000);
        cyc(); idle(); #1;
        check_eq("rd_wait_rv", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);
        cyc(); mem_rvalid_i = 1; mem_rdata_i = 64'hDEADBEEF; #1;
        check_eq("rd_i_rvalid", {63'd0, i_rvalid_o}, 64'd1);
        check_eq("rd_d_rvalid", {63'd0, d_rvalid_o}, 64'd0);
        check_eq("rd_i_rdata", i_rdata_o, 64'hDEADBEEF);
        cyc(); idle();

        // Continuous contention: grants go D, I, D, I after reset.
        do_reset();
        i_req_i = 1; i_addr_i = 64'h100; d_req_i = 1; d_addr_i = 64'h200; mem_gnt_i = 1; #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("rr_d_gnt", {63'd0, d_gnt_o}, (k % 2 == 0) ? 64'd1 : 64'd0);
            check_eq("rr_i_gnt", {63'd0, i_gnt_o}, (k % 2 == 0) ? 64'd0 : 64'd1);
            check_eq("rr_addr", mem_addr_o, (k % 2 == 0) ? 64'h200 : 64'h100);
            cyc(); #1;
        end
        idle(); mem_rvalid_i = 1; #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("rr_rsp_d", {63'd0, d_rvalid_o}, (k % 2 == 0) ? 64'd1 : 64'd0);
            check_eq("rr_rsp_i", {63'd0, i_rvalid_o}, (k % 2 == 0) ? 64'd0 : 64'd1);
            cyc(); #1;
        end
        idle();

        // Lock: I stalls at 0x40 for 3 cycles while higher-priority D waits.
        i_req_i = 1; i_addr_i = 64'h40; #1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin d_req_i = 1; d_addr_i = 64'h80; end
            if (k == 3) mem_gnt_i = 1;
            #1;
            check_eq("lk_addr", mem_addr_o, 64'h40);
            check_eq("lk_d_gnt", {63'd0, d_gnt_o}, 64'd0);
            check_eq("lk_i_gnt", {63'd0, i_gnt_o}, (k == 3) ? 64'd1 : 64'd0);
            cyc();
        end
        i_req_i = 0; #1;
        check_eq("lk_then_d", {63'd0, d_gnt_o}, 64'd1);
        check_eq("lk_then_addr", mem_addr_o, 64'h80);
        cyc(); idle();
        // FIFO holds [I, D]; pop the I entry.
        mem_rvalid_i = 1; #1;
        check_eq("pp_pop_i", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd2);
        cyc(); idle();
        // FIFO [D]; add another D -> [D, D].
        d_req_i = 1; mem_gnt_i = 1; #1;
        check_eq("pp_d_gnt", {63'd0, d_gnt_o}, 64'd1);
        cyc(); idle();
        // Simultaneous I handshake and D-head response: FIFO [D, I], count 2.
        i_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 64'h1111; #1;
        check_eq("sim_i_gnt", {63'd0, i_gnt_o}, 64'd1);
        check_eq("sim_rv", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd1);
        check_eq("sim_d_rdata", d_rdata_o, 64'h1111);
        cyc(); idle();
        // Two more D grants reach count 4, the next request is held off.
        d_req_i = 1; mem_gnt_i = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("fill_d_gnt", {63'd0, d_gnt_o}, 64'd1);
            cyc();
        end
        #1;
        check_eq("full_mem_req", {63'd0, mem_req_o}, 64'd0);
        check_eq("full_d_gnt", {63'd0, d_gnt_o}, 64'd0);
        cyc();
        // Response while full: no bypass, still blocked this cycle.
        mem_rvalid_i = 1; #1;
        check_eq("full_pop_req", {63'd0, mem_req_o}, 64'd0);
        check_eq("full_pop_rv", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd1);
        cyc(); mem_rvalid_i = 0; #1;
        check_eq("resume_req", {63'd0, mem_req_o}, 64'd1);
        check_eq("resume_gnt", {63'd0, d_gnt_o}, 64'd1);
        cyc(); idle();
        // Drain FIFO [I, D, D, D].
        mem_rvalid_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("drain_rv", {62'd0, i_rvalid_o, d_rvalid_o}, (k == 0) ? 64'd2 : 64'd1);
            cyc();
        end
        mem_rvalid_i = 0; #1;
        check_eq("pre_err", {63'd0, err_o}, 64'd0);

        // Unexpected response: dropped, sticky error until reset.
        mem_rvalid_i = 1; #1;
        check_eq("unexp_rv", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);
        cyc(); mem_rvalid_i = 0; #1;
        check_eq("err_set", {63'd0, err_o}, 64'd1);
        cyc(); cyc(); #1;
        check_eq("err_sticky", {63'd0, err_o}, 64'd1);
        rst_ni = 0; #1;
        check_eq("err_cleared", {63'd0, err_o}, 64'd0);
        cyc(); rst_ni = 1; #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
